bcd_disp_mux: RTL and testbench

- Consumer end of the BCD digit interface that counters and timers (e.g. the stopwatch) drive.
- Takes four BCD digits plus decimal-point and blank controls, and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Digit values are snapshotted once per scan frame, so a counter changing mid-frame never produces a torn display.
- Sits between the counter/timer logic and the board display pins.

---
 rtl/bcd_disp_mux_pkg.sv | 29 ++
 rtl/bcd_disp_mux_if.sv | 25 ++
 rtl/bcd_disp_mux_bcd_to_sseg.sv | 26 ++
 rtl/bcd_disp_mux.sv | 101 ++++++++++
 tb/tb_bcd_disp_mux.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_mux_pkg.sv
// Shared 7-segment display types and active-low glyph constants.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package disp_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [1:0] digit_idx_t;

   localparam int unsigned NUM_DIGITS = 4;

   localparam seg7_t SEG_BLANK = 7'h7F;
   localparam seg7_t SEG_DASH  = 7'h3F;

   localparam seg7_t SEG_0 = 7'h40;
   localparam seg7_t SEG_1 = 7'h79;
   localparam seg7_t SEG_2 = 7'h24;
   localparam seg7_t SEG_3 = 7'h30;
   localparam seg7_t SEG_4 = 7'h19;
   localparam seg7_t SEG_5 = 7'h12;
   localparam seg7_t SEG_6 = 7'h02;
   localparam seg7_t SEG_7 = 7'h78;
   localparam seg7_t SEG_8 = 7'h00;
   localparam seg7_t SEG_9 = 7'h10;

   // Active-low anode pattern that enables only digit idx.
   function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/bcd_disp_mux_if.sv
// BCD digit bus from a counter/timer plus the multiplexed display pins.
// The producer uses master; the display multiplexer uses slave.
interface bcd_disp_mux_if;

   logic [3:0] d3;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic [3:0] dp_in;
   logic [3:0] blank;
   logic [3:0] an;
   logic [7:0] sseg;
   logic       frame_tick;

   modport master (
      output d3, d2, d1, d0, dp_in, blank,
      input  an, sseg, frame_tick
   );

   modport slave (
      input  d3, d2, d1, d0, dp_in, blank,
      output an, sseg, frame_tick
   );

endinterface

// File: rtl/bcd_disp_mux_bcd_to_sseg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_sseg
   import disp_pkg::*;
(
   input  logic [3:0] bcd,
   output seg7_t      seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_disp_mux.sv
// Four-digit common-anode display multiplexer with once-per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module bcd_disp_mux
   import disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 250000
) (
   input  logic           clk,
   input  logic           reset,
   bcd_disp_mux_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;
   logic             first_q, first_d;
   logic [3:0][3:0]  dig_q, dig_d;
   logic [3:0]       dp_q, dp_d;
   logic [3:0]       blank_q, blank_d;
   logic             ft_q, ft_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       sseg_q, sseg_d;

   logic             term;
   logic             capture;
   logic [3:0]       lead_blank;
   seg7_t            glyph;

   always_comb begin
      term    = (cnt_q == CNT_LAST);
      cnt_d   = term ? '0 : cnt_q + CNT_W'(1);
      idx_d   = term ? idx_q + digit_idx_t'(1) : idx_q;
      // first_q forces a capture on the very first cycle out of reset
      capture = first_q | (term & (idx_q == digit_idx_t'(3)));
      first_d = 1'b0;
      ft_d    = capture;
      dig_d   = capture ? {bus.d3, bus.d2, bus.d1, bus.d0} : dig_q;
      dp_d    = capture ? bus.dp_in : dp_q;
      blank_d = capture ? bus.blank : blank_q;
   end

   bcd_to_sseg u_dec (
      .bcd (dig_q[idx_q]),
      .seg (glyph)
   );

   always_comb begin
      lead_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      lead_blank[3] = (dig_q[3] == 4'd0);
      lead_blank[2] = lead_blank[3] & (dig_q[2] == 4'd0);
      lead_blank[1] = lead_blank[2] & (dig_q[1] == 4'd0);
`endif
   end

   always_comb begin
      an_d   = '1;
      sseg_d = '1;
      // Hold the display dark until the first snapshot has landed
      if (!first_q) begin
         an_d = anode_sel(idx_q);
         if (blank_q[idx_q])
            sseg_d = '1;
         else if (lead_blank[idx_q])
            sseg_d = {~dp_q[idx_q], SEG_BLANK};
         else
            sseg_d = {~dp_q[idx_q], glyph};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         first_q <= 1'b1;
         dig_q   <= '0;
         dp_q    <= '0;
         blank_q <= '0;
         ft_q    <= 1'b0;
         an_q    <= '1;
         sseg_q  <= '1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         first_q <= first_d;
         dig_q   <= dig_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         ft_q    <= ft_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.sseg       = sseg_q;
   assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Scoreboard bench for bcd_disp_mux at REFRESH_DIV=4 and REFRESH_DIV=2.
// Expected outputs come from a time-based model of the frame schedule.
module tb_bcd_disp_mux;

   localparam int RD [2] = '{4, 2};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] d3, d2, d1, d0, dp_in, blank;

   always #5 clk = ~clk;

   bcd_disp_mux_if ifa ();
   bcd_disp_mux_if ifb ();

   assign ifa.d3 = d3;  assign ifa.d2 = d2;  assign ifa.d1 = d1;  assign ifa.d0 = d0;
   assign ifa.dp_in = dp_in;  assign ifa.blank = blank;
   assign ifb.d3 = d3;  assign ifb.d2 = d2;  assign ifb.d1 = d1;  assign ifb.d0 = d0;
   assign ifb.dp_in = dp_in;  assign ifb.blank = blank;

   bcd_disp_mux #(.REFRESH_DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   bcd_disp_mux #(.REFRESH_DIV(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] sseg;
      logic       ft;
   } exp_t;

   exp_t        q_a [$];
   exp_t        q_b [$];
   int unsigned checks = 0;
   int unsigned passes = 0;
   int          rel  [2];
   logic [23:0] snap [2];

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // s = {d3,d2,d1,d0,dp[3:0],blank[3:0]}
   function automatic logic [7:0] exp_seg(input logic [23:0] s, input int p);
      logic lead;
      if (s[p]) return 8'hFF;
      lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (p > 0) begin
         lead = 1'b1;
         for (int j = p; j < 4; j++)
            if (s[8+4*j +: 4] != 4'd0) lead = 1'b0;
      end
`endif
      if (lead) return {~s[4+p], 7'h7F};
      return {~s[4+p], glyph(s[8+4*p +: 4])};
   endfunction

   // k counts clock edges since reset release; each digit owns R edges, a frame 4R.
   task automatic model_step(input int i, output exp_t e);
      int  k;
      int  r;
      logic cap;
      r = RD[i];
      if (reset) begin
         rel[i]  = 0;
         snap[i] = '0;
         e = '{an: 4'hF, sseg: 8'hFF, ft: 1'b0};
      end else begin
         k = rel[i];
         rel[i] = rel[i] + 1;
         if (k == 0) begin
            e.an   = 4'hF;
            e.sseg = 8'hFF;
         end else begin
            e.an   = ~(4'b0001 << ((k / r) % 4));
            e.sseg = exp_seg(snap[i], (k / r) % 4);
         end
         cap  = (k == 0) || (((k + 1) % (4 * r)) == 0);
         e.ft = cap;
         if (cap) snap[i] = {d3, d2, d1, d0, dp_in, blank};
      end
   endtask

   always @(posedge clk) begin
      exp_t ea, eb;
      model_step(0, ea);
      model_step(1, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
   end

   task automatic compare(input string name, input int v_got, input int v_exp);
      checks++;
      if (v_got == v_exp) passes++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, v_got, v_exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         compare("div4 an",         int'(ifa.an),         int'(e.an));
         compare("div4 sseg",       int'(ifa.sseg),       int'(e.sseg));
         compare("div4 frame_tick", int'(ifa.frame_tick), int'(e.ft));
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         compare("div2 an",         int'(ifb.an),         int'(e.an));
         compare("div2 sseg",       int'(ifb.sseg),       int'(e.sseg));
         compare("div2 frame_tick", int'(ifb.frame_tick), int'(e.ft));
      end
   end

   task automatic wait_an(input logic [3:0] target);
      int n;
      n = 0;
      while (ifa.an !== target && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ifa.an === target) passes++;
      else $display("FAIL wait_an: got %b expected %b within 100 cycles", ifa.an, target);
   endtask

   task automatic set_digits(input logic [3:0] a3, a2, a1, a0);
      d3 = a3; d2 = a2; d1 = a1; d0 = a0;
   endtask

   function automatic logic [3:0] rnd_digit();
      if ($urandom_range(0, 2) == 0) return 4'd0;
      return 4'($urandom_range(0, 15));
   endfunction

   initial begin
      reset = 1'b1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      dp_in = '0;
      blank = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      wait_an(4'b1101);
      d0 = 4'd7;
      repeat (40) @(negedge clk);

      d1 = 4'd12;
      dp_in = 4'b0100;
      repeat (34) @(negedge clk);
      blank = 4'b1000;
      repeat (34) @(negedge clk);
      blank = '0;
      dp_in = '0;

      wait_an(4'b1011);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (34) @(negedge clk);

      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      repeat (34) @(negedge clk);
      set_digits(4'd0, 4'd1, 4'd0, 4'd5);
      repeat (34) @(negedge clk);

      for (int it = 0; it < 60; it++) begin
         set_digits(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
         dp_in = 4'($urandom_range(0, 15));
         blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         if ($urandom_range(0, 15) == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         repeat ($urandom_range(1, 20)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
